// File: rtl/bexkat_regfile_pkg.sv
// Shared register-file types for the write-port arbiter and its users.
package bexkat_regfile_pkg;

    localparam int REG_AW  = 5;
    localparam int REG_DW  = 16;
    localparam int REG_NUM = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

endpackage

// File: rtl/regfile_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping mod NREQ.
module regfile_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [PW:0]   sum;
    logic [PW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // explicit wrap keeps non-power-of-2 NREQ in range
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ))
                sum = sum - (PW+1)'(NREQ);
            j = sum[PW-1:0];
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port among NREQ producers, one registered write per cycle.
// Build option: REGFILE_ARB_R0_DISCARD_EN drops accepted writes to register 0.
module regfile_write_arbiter
    import bexkat_regfile_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW,
    parameter int CNTW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic             stall,
    output logic [AW-1:0]    write_addr,
    output logic [DW-1:0]    write_data,
    output logic             write_en,
    output logic             pend_valid,
    output logic [AW-1:0]    pend_addr,
    output logic [CNTW-1:0]  conflict_cnt
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] req_elig;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   win_idx;
    logic            accept;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic            wr_fire;
    logic            multi_req;

    assign req_elig = (rst || stall) ? '0 : req_valid;

    regfile_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (req_elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (accept)
    );

    assign req_ready = grant;
    assign win_addr  = req_addr[win_idx*AW +: AW];
    assign win_data  = req_data[win_idx*DW +: DW];

`ifdef REGFILE_ARB_R0_DISCARD_EN
    // r0 writes are handshaken away but never reach the port
    assign wr_fire = accept && (win_addr != '0);
`else
    assign wr_fire = accept;
`endif

    // x & (x-1) is nonzero iff at least two bits are set
    assign multi_req = |(req_valid & (req_valid - 1'b1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            write_en     <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            conflict_cnt <= '0;
        end else begin
            write_en <= wr_fire;
            if (wr_fire) begin
                write_addr <= win_addr;
                write_data <= win_data;
            end
            if (accept)
                rr_ptr <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
            if (multi_req && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign pend_valid = write_en;
    assign pend_addr  = write_addr;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a behavioural producer/port model.
// Honours REGFILE_ARB_R0_DISCARD_EN when defined for the build.
module tb_regfile_write_arbiter;
    import bexkat_regfile_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = REG_AW;
    localparam int DW   = REG_DW;
    localparam int CNTW = 16;
    localparam int CMAX = (1 << CNTW) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               stall;
    logic [AW-1:0]      write_addr;
    logic [DW-1:0]      write_data;
    logic               write_en;
    logic               pend_valid;
    logic [AW-1:0]      pend_addr;
    logic [CNTW-1:0]    conflict_cnt;

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .stall        (stall),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_en     (write_en),
        .pend_valid   (pend_valid),
        .pend_addr    (pend_addr),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state: producers' pending writes and what the port should show
    bit      pv   [NREQ];
    wr_req_t preq [NREQ];
    int      ptr;
    bit      m_we;
    int      m_wa, m_wd, m_cnt;
    int      grants_seen [NREQ];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
    endtask

    // one clock: check registered outputs, drive inputs, check ready, advance model
    task automatic cyc(input bit r, input bit s);
        int g, n, j;
        bit disc;
        @(negedge clk);
        chk("write_en", write_en, m_we);
        chk("pend_valid", pend_valid, m_we);
        chk("write_addr", write_addr, m_wa);
        chk("pend_addr", pend_addr, m_wa);
        chk("write_data", write_data, m_wd);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        rst = r;
        stall = s;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pv[i];
            req_addr[i*AW +: AW] = preq[i].addr;
            req_data[i*DW +: DW] = preq[i].data;
        end
        #1;
        g = -1;
        n = 0;
        for (int i = 0; i < NREQ; i++) n += pv[i];
        if (!r && !s)
            for (int k = 0; k < NREQ; k++) begin
                j = (ptr + k) % NREQ;
                if (g < 0 && pv[j]) g = j;
            end
        chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        if (r) begin
            model_reset();
        end else begin
            if (n >= 2 && m_cnt < CMAX) m_cnt++;
            m_we = 0;
            if (g >= 0) begin
                disc = 0;
`ifdef REGFILE_ARB_R0_DISCARD_EN
                disc = (preq[g].addr == 0);
`endif
                if (!disc) begin
                    m_we = 1;
                    m_wa = preq[g].addr;
                    m_wd = preq[g].data;
                end
                ptr = (g + 1) % NREQ;
                pv[g] = 0;
                grants_seen[g]++;
            end
        end
    endtask

    task automatic set_req(input int i, input int a, input int d);
        pv[i] = 1;
        preq[i].addr = reg_addr_t'(a);
        preq[i].data = reg_data_t'(d);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 0; preq[i] = '0; grants_seen[i] = 0;
        end
        model_reset();
        @(posedge clk);

        // reset held with everyone requesting
        for (int i = 0; i < NREQ; i++) set_req(i, 8 + i, 16'h1000 + i);
        cyc(1, 0);
        cyc(1, 0);
        for (int i = 0; i < NREQ; i++) pv[i] = 0;
        cyc(1, 0);

        // lone requester 1
        set_req(1, 5, 16'hBEEF);
        cyc(0, 0);
        cyc(0, 0);
        cyc(1, 0);

        // all four from ptr 0, then a drained cycle
        for (int i = 0; i < NREQ; i++) set_req(i, 16 + i, 16'hA000 + i);
        repeat (5) cyc(0, 0);

        // stall right after an accept
        set_req(0, 3, 16'h0333);
        set_req(1, 4, 16'h0444);
        cyc(0, 0);
        cyc(0, 1);
        cyc(0, 1);
        repeat (3) cyc(0, 0);

        // reset lands while a write is in flight
        set_req(2, 7, 16'h0777);
        cyc(0, 0);
        set_req(3, 9, 16'h0999);
        cyc(1, 0);
        set_req(0, 10, 16'h0AAA);
        repeat (3) cyc(0, 0);

        // register-0 write from requester 2
        cyc(1, 0);
        set_req(2, 0, 16'h5A5A);
        repeat (3) cyc(0, 0);

        // randomized traffic with legal handshake behaviour
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pv[i] && ($urandom_range(0, 99) < 55))
                    set_req(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, REG_NUM - 1),
                            $urandom_range(0, 16'hFFFF));
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15);
        end
        for (int i = 0; i < NREQ; i++) pv[i] = 0;
        repeat (2) cyc(0, 0);

        for (int i = 0; i < NREQ; i++)
            chk("grant_coverage", grants_seen[i] > 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
